button_event: RTL and testbench

//  Turns one debounced button level into single-cycle event pulses: press, release,

---
 rtl/button_event_pkg.sv | 30 +++
 rtl/button_event_if.sv | 32 +++
 rtl/button_event_ms_tick.sv | 34 +++
 rtl/button_event.sv | 155 +++++++++++++++
 tb/tb_button_event.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/button_event_pkg.sv
// button_event_pkg
//   Shared types and helpers for the button event block.
//   - state_t   : FSM state encoding (IDLE=0, HOLD=1, REPEAT=2)
//   - HOLD_MS_W : width of the hold duration report
//   - get_width : bits needed to represent a non-negative value (minimum 1)
//   - max_int   : larger of two integers, for sizing shared counters
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int HOLD_MS_W = 16;

  function automatic int get_width(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_if.sv
// button_event_if
//   Event bundle between one button_event instance and its consumer.
//   en, btn_i            : controls into the block (enable, debounced level)
//   press_o, release_o,
//   long_o, repeat_o     : single-cycle event pulses out of the block
//   held_o               : level, high while an accepted press is held
//   hold_ms              : ms elapsed since the last accepted press (saturating)
//   master : the side that drives en/btn_i (UI glue or testbench)
//   slave  : the button_event block itself
interface button_event_if;
  import button_event_pkg::*;

  logic                 en;
  logic                 btn_i;
  logic                 press_o;
  logic                 release_o;
  logic                 long_o;
  logic                 repeat_o;
  logic                 held_o;
  logic [HOLD_MS_W-1:0] hold_ms;

  modport master (
    output en, btn_i,
    input  press_o, release_o, long_o, repeat_o, held_o, hold_ms
  );

  modport slave (
    input  en, btn_i,
    output press_o, release_o, long_o, repeat_o, held_o, hold_ms
  );

endinterface

// File: rtl/button_event_ms_tick.sv
// ms_tick
//   Millisecond strobe generator. tick is a 1-cycle pulse every
//   CLK_FREQ*1000 clock cycles; clr restarts the period so the first tick
//   after a clr lands a full period later.
//   clk  : main clock
//   rst  : synchronous reset, active-high
//   clr  : restart the period
//   tick : 1-cycle ms strobe
module ms_tick
  import button_event_pkg::*;
#(
  parameter int CLK_FREQ = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int TICK = CLK_FREQ * 1000;
  localparam int CW   = get_width(TICK - 1);

  logic [CW-1:0] cnt;

  // Down-counter; terminal count 0 is the strobe and also reloads.
  always_ff @(posedge clk) begin
    if (rst || clr || (cnt == '0)) cnt <= CW'(TICK - 1);
    else                           cnt <= cnt - 1'b1;
  end

  // tick depends only on cnt, never on clr, so a caller may derive clr from tick.
  assign tick = (cnt == '0);

endmodule

// File: rtl/button_event.sv
// button_event
//   Turns one debounced button level into single-cycle press / release /
//   long-press / auto-repeat pulses and reports the hold duration in ms.
//   clk : main clock
//   rst : synchronous reset, active-high
//   bus : button_event_if.slave (en, btn_i in; event pulses, held_o, hold_ms out)
//
//   state  | meaning
//   IDLE   | no accepted press; waits for btn_i=1 while armed
//   HOLD   | press accepted, counting towards LONG_MS
//   REPEAT | long press reported, emitting repeat pulses every REPEAT_MS
module button_event
  import button_event_pkg::*;
#(
  parameter int CLK_FREQ  = 100,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int REPEAT_EN = 1
) (
  input  logic clk,
  input  logic rst,
  button_event_if.slave bus
);

  localparam int MW = get_width(max_int(LONG_MS, REPEAT_MS));

  state_t               state, state_nxt;
  logic                 armed, armed_nxt;
  logic                 long_done, long_done_nxt;
  logic [MW-1:0]        ms_cnt, ms_cnt_nxt, ms_inc;
  logic [HOLD_MS_W-1:0] hold_q, hold_nxt;
  logic                 press_q, press_nxt;
  logic                 release_q, release_nxt;
  logic                 long_q, long_nxt;
  logic                 repeat_q, repeat_nxt;
  logic                 held_q, held_nxt;
  logic                 tick, tick_clr;

  ms_tick #(.CLK_FREQ(CLK_FREQ)) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      long_done <= 1'b0;
      ms_cnt    <= '0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      armed     <= armed_nxt;
      long_done <= long_done_nxt;
      ms_cnt    <= ms_cnt_nxt;
      hold_q    <= hold_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      long_q    <= long_nxt;
      repeat_q  <= repeat_nxt;
      held_q    <= held_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    armed_nxt     = armed;
    long_done_nxt = long_done;
    ms_cnt_nxt    = ms_cnt;
    hold_nxt      = hold_q;
    held_nxt      = held_q;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    long_nxt      = 1'b0;
    repeat_nxt    = 1'b0;
    tick_clr      = 1'b0;
    ms_inc        = ms_cnt + 1'b1;

    case (state)
      IDLE: begin
        // Arming requires seeing the button released while enabled, so a
        // level held across reset or an en rise is never taken as a press.
        if (!bus.en) begin
          armed_nxt = 1'b0;
        end else if (!bus.btn_i) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          press_nxt     = 1'b1;
          held_nxt      = 1'b1;
          hold_nxt      = '0;
          ms_cnt_nxt    = '0;
          long_done_nxt = 1'b0;
          armed_nxt     = 1'b0;
          tick_clr      = 1'b1;
          state_nxt     = HOLD;
        end
      end

      HOLD, REPEAT: begin
        if (!bus.en) begin
          // Silent abort: no release pulse, hold_ms keeps its value.
          armed_nxt = 1'b0;
          held_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (!bus.btn_i) begin
          // Release has priority over a long/repeat due in the same cycle.
          release_nxt = 1'b1;
          held_nxt    = 1'b0;
          armed_nxt   = 1'b1;
          state_nxt   = IDLE;
        end else if (tick) begin
          if (hold_q != '1) hold_nxt = hold_q + 1'b1;
          if (state == HOLD) begin
            if (!long_done) begin
              if (ms_inc == MW'(LONG_MS)) begin
                long_nxt   = 1'b1;
                ms_cnt_nxt = '0;
                tick_clr   = 1'b1;
                if (REPEAT_EN != 0) state_nxt     = REPEAT;
                else                long_done_nxt = 1'b1;
              end else begin
                ms_cnt_nxt = ms_inc;
              end
            end
          end else begin
            if (ms_inc == MW'(REPEAT_MS)) begin
              repeat_nxt = 1'b1;
              ms_cnt_nxt = '0;
              tick_clr   = 1'b1;
            end else begin
              ms_cnt_nxt = ms_inc;
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.press_o   = press_q;
  assign bus.release_o = release_q;
  assign bus.long_o    = long_q;
  assign bus.repeat_o  = repeat_q;
  assign bus.held_o    = held_q;
  assign bus.hold_ms   = hold_q;

endmodule

// File: tb/tb_button_event.sv
// tb_button_event
//   Directed bench for button_event with TICK=1000, LONG_MS=3, REPEAT_MS=2.
//   dut_a has auto-repeat enabled, dut_b has it disabled; both see the same
//   clk/rst/en/btn stimulus.
module tb_button_event;
  import button_event_pkg::*;

  logic clk;
  logic rst;
  logic en;
  logic btn;

  int checks = 0;
  int errors = 0;

  int n_press_a = 0, n_rel_a = 0, n_long_a = 0, n_rep_a = 0;
  int n_long_b  = 0, n_rep_b = 0;
  int snap_a, snap_b, snap_c;

  button_event_if bus_a ();
  button_event_if bus_b ();

  assign bus_a.en    = en;
  assign bus_a.btn_i = btn;
  assign bus_b.en    = en;
  assign bus_b.btn_i = btn;

  button_event #(.CLK_FREQ(1), .LONG_MS(3), .REPEAT_MS(2), .REPEAT_EN(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  button_event #(.CLK_FREQ(1), .LONG_MS(3), .REPEAT_MS(2), .REPEAT_EN(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus_a.press_o)   n_press_a++;
    if (bus_a.release_o) n_rel_a++;
    if (bus_a.long_o)    n_long_a++;
    if (bus_a.repeat_o)  n_rep_a++;
    if (bus_b.long_o)    n_long_b++;
    if (bus_b.repeat_o)  n_rep_b++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    btn = 1'b0;
    step(3);
    check_bit("rst_press",   bus_a.press_o,   1'b0);
    check_bit("rst_release", bus_a.release_o, 1'b0);
    check_bit("rst_long",    bus_a.long_o,    1'b0);
    check_bit("rst_repeat",  bus_a.repeat_o,  1'b0);
    check_bit("rst_held",    bus_a.held_o,    1'b0);
    check_val("rst_hold_ms", int'(bus_a.hold_ms), 0);
    check_val("rst_state",   int'(dut_a.state), int'(IDLE));

    // 1: press accepted one cycle after the rising edge is sampled
    rst = 1'b0;
    step(5);
    btn = 1'b1;
    step(1);
    check_bit("t1_press",   bus_a.press_o, 1'b1);
    check_bit("t1_held",    bus_a.held_o,  1'b1);
    check_val("t1_hold_ms", int'(bus_a.hold_ms), 0);
    step(1);
    check_bit("t1_press_single", bus_a.press_o, 1'b0);
    check_bit("t1_held_on",      bus_a.held_o,  1'b1);

    // 2: long at press+3000, repeats at long+2000 and long+4000
    step(2998);
    check_bit("t2_long_early", bus_a.long_o, 1'b0);
    step(1);
    check_bit("t2_long",      bus_a.long_o, 1'b1);
    check_val("t2_long_ms",   int'(bus_a.hold_ms), 3);
    check_bit("t2_long_b",    bus_b.long_o, 1'b1);
    step(1);
    check_bit("t2_long_single", bus_a.long_o, 1'b0);
    step(1998);
    check_bit("t2_rep1_early", bus_a.repeat_o, 1'b0);
    step(1);
    check_bit("t2_rep1",    bus_a.repeat_o, 1'b1);
    check_val("t2_rep1_ms", int'(bus_a.hold_ms), 5);
    step(1999);
    check_bit("t2_rep2_early", bus_a.repeat_o, 1'b0);
    step(1);
    check_bit("t2_rep2",    bus_a.repeat_o, 1'b1);
    check_val("t2_rep2_ms", int'(bus_a.hold_ms), 7);
    step(1);
    btn = 1'b0;
    step(1);
    check_bit("t2_release",   bus_a.release_o, 1'b1);
    check_bit("t2_held_off",  bus_a.held_o,    1'b0);
    check_val("t2_hold_kept", int'(bus_a.hold_ms), 7);
    step(1);
    check_bit("t2_release_single", bus_a.release_o, 1'b0);

    // 3: release 1500 cycles after press, no long ever
    btn = 1'b1;
    step(1);
    check_bit("t3_press", bus_a.press_o, 1'b1);
    snap_a = n_long_a;
    step(1499);
    btn = 1'b0;
    step(1);
    check_bit("t3_release", bus_a.release_o, 1'b1);
    check_val("t3_hold_ms", int'(bus_a.hold_ms), 1);
    step(3000);
    check_val("t3_no_long",    n_long_a, snap_a);
    check_val("t3_hold_after", int'(bus_a.hold_ms), 1);

    // 4: release sampled on the edge where long is due
    btn = 1'b1;
    step(1);
    check_bit("t4_press", bus_a.press_o, 1'b1);
    snap_a = n_long_a;
    step(2999);
    btn = 1'b0;
    step(1);
    check_bit("t4_release", bus_a.release_o, 1'b1);
    check_bit("t4_no_long", bus_a.long_o,    1'b0);
    check_val("t4_state",   int'(dut_a.state), int'(IDLE));
    step(5);
    check_val("t4_long_cnt", n_long_a, snap_a);

    // 5: button held across reset is not a press until released
    btn = 1'b1;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    snap_a = n_press_a;
    step(20);
    check_val("t5_no_press", n_press_a, snap_a);
    check_bit("t5_held_off", bus_a.held_o, 1'b0);
    btn = 1'b0;
    step(1);
    btn = 1'b1;
    step(1);
    check_bit("t5_press", bus_a.press_o, 1'b1);

    // 6: en drop during REPEAT aborts silently
    step(3000);
    check_bit("t6_long",  bus_a.long_o, 1'b1);
    check_val("t6_state", int'(dut_a.state), int'(REPEAT));
    step(100);
    snap_a = n_press_a + n_rel_a + n_long_a + n_rep_a;
    en = 1'b0;
    step(1);
    check_bit("t6_held_off", bus_a.held_o, 1'b0);
    step(9);
    en = 1'b1;
    step(1);
    check_bit("t6_held_en", bus_a.held_o, 1'b0);
    step(3000);
    check_val("t6_no_pulses", n_press_a + n_rel_a + n_long_a + n_rep_a, snap_a);
    check_val("t6_hold_ms",   int'(bus_a.hold_ms), 3);
    btn = 1'b0;
    step(1);
    check_bit("t6_no_release", bus_a.release_o, 1'b0);
    step(1);
    btn = 1'b1;
    step(1);
    check_bit("t6_repress", bus_a.press_o, 1'b1);

    // REPEAT_EN=0 variant against the repeating instance
    btn = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
    snap_a = n_rep_a;
    snap_b = n_long_b;
    snap_c = n_rep_b;
    btn = 1'b1;
    step(12000);
    check_val("v_long_b_once", n_long_b - snap_b, 1);
    check_val("v_rep_b_none",  n_rep_b - snap_c,  0);
    check_val("v_rep_a_four",  n_rep_a - snap_a,  4);
    check_bit("v_held_b",      bus_b.held_o, 1'b1);
    btn = 1'b0;
    step(1);
    check_bit("v_release_b", bus_b.release_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
